// File: rtl/lmac_txfifo_rd_ctrl.sv
// Read-side controller of the LMAC TX packet-data FIFO: occupancy tracking, buffer fetch, valid/ready output.
// Optional rate pacing of buffer fetches is enabled by defining LMAC_TXFIFO_RD_PACE_EN.
module lmac_txfifo_rd_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PTR_W  = 5,
    parameter int unsigned CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_push,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [PTR_W-1:0]  buf_rd_addr,
    output logic              buf_rd_en,
    output logic              rd_pop,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic              rd_empty,
    output logic [CNT_W-1:0]  rd_used,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              mode_10g,
    input  logic              mode_5g,
    input  logic              mode_2p5g,
    input  logic              mode_1g
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  used_q, used_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;

    logic clr;
    logic full;
    logic accept;
    logic pace_ok;
    logic fetch;
    logic push_ok;

    assign clr     = rst | flush;
    assign rd_empty = (used_q == '0);
    assign full    = (used_q == CNT_W'(DEPTH));
    assign accept  = out_valid_q & out_ready;
    assign push_ok = wr_push & ~full;

`ifdef LMAC_TXFIFO_RD_PACE_EN
    logic [3:0] pace_cnt_q, pace_cnt_d;
    logic [3:0] pace_reload;

    always_comb begin
        if (mode_10g)       pace_reload = 4'd0;
        else if (mode_5g)   pace_reload = 4'd1;
        else if (mode_2p5g) pace_reload = 4'd3;
        else if (mode_1g)   pace_reload = 4'd9;
        else                pace_reload = 4'd0;

        pace_cnt_d = pace_cnt_q;
        if (clr)
            pace_cnt_d = '0;
        else if (fetch)
            pace_cnt_d = pace_reload;
        else if (pace_cnt_q != '0)
            pace_cnt_d = pace_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        pace_cnt_q <= pace_cnt_d;
    end

    assign pace_ok = (pace_cnt_q == '0);
`else
    logic unused_modes;
    assign unused_modes = mode_10g ^ mode_5g ^ mode_2p5g ^ mode_1g;
    assign pace_ok      = 1'b1;
`endif

    // Fetch is combinational so the buffer's one-cycle read lands exactly in FETCH.
    always_comb begin
        fetch = 1'b0;
        if (!clr && !rd_empty && pace_ok) begin
            case (state_q)
                S_IDLE:  fetch = 1'b1;
                S_HOLD:  fetch = accept;
                default: fetch = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        used_d      = used_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (clr) begin
            state_d     = S_IDLE;
            rd_ptr_d    = '0;
            used_d      = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            if (rst)
                overflow_d = 1'b0;
        end else begin
            if (fetch)
                rd_ptr_d = (rd_ptr_q >= PTR_W'(DEPTH)) ? PTR_W'(1) : rd_ptr_q + 1'b1;

            if (wr_push && full)
                overflow_d = 1'b1;

            case ({push_ok, fetch})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (fetch)
                        state_d = S_FETCH;
                end
                S_FETCH: begin
                    out_data_d  = buf_rd_data;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
                S_HOLD: begin
                    if (accept) begin
                        out_valid_d = 1'b0;
                        state_d     = fetch ? S_FETCH : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        rd_ptr_q    <= rd_ptr_d;
        used_q      <= used_d;
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
        overflow_q  <= overflow_d;
    end

    assign buf_rd_addr = (rd_ptr_q == PTR_W'(DEPTH)) ? '0 : rd_ptr_q;
    assign buf_rd_en   = fetch;
    assign rd_pop      = fetch;
    assign rd_ptr      = rd_ptr_q;
    assign rd_used     = used_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_lmac_txfifo_rd_ctrl.sv
// Self-checking bench for lmac_txfifo_rd_ctrl: buffer/writer model, output scoreboard and directed steps.
`timescale 1ns/1ps
module tb_lmac_txfifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_push = 1'b0;
    logic [63:0] wr_data = '0;
    logic [63:0] buf_rd_data = '0;
    logic [4:0]  buf_rd_addr;
    logic        buf_rd_en;
    logic        rd_pop;
    logic [4:0]  rd_ptr;
    logic        rd_empty;
    logic [12:0] rd_used;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        mode_10g = 1'b0;
    logic        mode_5g = 1'b0;
    logic        mode_2p5g = 1'b0;
    logic        mode_1g = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [16];
    logic [63:0] exp_q [$];
    time         fetch_t [$];
    int          tb_count = 0;
    logic [3:0]  waddr = '0;
    logic [3:0]  exp_addr = '0;
    logic        exp_ovf = 1'b0;
    int          pop_cnt = 0;
    int          out_cnt = 0;

`ifdef LMAC_TXFIFO_RD_PACE_EN
    localparam int GAP = 10;
`else
    localparam int GAP = 2;
`endif

    lmac_txfifo_rd_ctrl #(.DEPTH(16), .DATA_W(64), .PTR_W(5), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_push(wr_push),
        .buf_rd_data(buf_rd_data), .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en),
        .rd_pop(rd_pop), .rd_ptr(rd_ptr), .rd_empty(rd_empty), .rd_used(rd_used),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .mode_10g(mode_10g), .mode_5g(mode_5g),
        .mode_2p5g(mode_2p5g), .mode_1g(mode_1g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer RAM: read data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (buf_rd_en)
            buf_rd_data <= mem[buf_rd_addr[3:0]];
    end

    // Writer model, fetch-address model and output scoreboard.
    always @(negedge clk) begin
        if (rst)
            exp_ovf = 1'b0;
        if (rst || flush) begin
            exp_q.delete();
            tb_count = 0;
            waddr    = '0;
            exp_addr = '0;
        end else begin
            if (buf_rd_en) begin
                chk("rd_pop_with_fetch", rd_pop, 1);
                chk("rd_addr", buf_rd_addr, exp_addr);
                exp_addr = exp_addr + 4'd1;
                pop_cnt++;
                fetch_t.push_back($time);
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_extra: observed %0h expected no output", out_data);
                end
                if (exp_q.size() != 0)
                    chk("out_data", out_data, exp_q.pop_front());
                out_cnt++;
            end
            if (wr_push) begin
                if (tb_count < 16) begin
                    mem[waddr] = wr_data;
                    exp_q.push_back(wr_data);
                    waddr = waddr + 4'd1;
                    tb_count++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (buf_rd_en)
                tb_count--;
        end
    end

    initial begin
        int p0, o0, n;
        logic [63:0] base_v;

        // 1. reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_rd_used", rd_used, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_buf_rd_en", buf_rd_en, 0);

        // 2. three pushes, downstream always ready, latency check
        tick();
        out_ready = 1'b1;
        p0 = pop_cnt;
        o0 = out_cnt;
        wr_push = 1'b1;
        wr_data = 64'hA1;
        tick();
        wr_data = 64'hA2;
        @(negedge clk);
        chk("lat_fetch_next_cycle", buf_rd_en, 1);
        tick();
        wr_data = 64'hA3;
        @(negedge clk);
        chk("lat_not_yet_valid", out_valid, 0);
        tick();
        wr_push = 1'b0;
        @(negedge clk);
        chk("lat_valid_two_after_fetch", out_valid, 1);
        repeat (10) tick();
        @(negedge clk);
        chk("t2_pops", pop_cnt - p0, 3);
        chk("t2_outputs", out_cnt - o0, 3);
        chk("t2_empty", rd_empty, 1);
        chk("t2_rd_ptr", rd_ptr, 3);

        // 3. fill to DEPTH with output stalled, overflow on the next push, then drain
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        o0 = out_cnt;
        for (int i = 0; i < 17; i++) begin
            wr_push = 1'b1;
            base_v = 64'h100;
            wr_data = base_v + 64'(i);
            tick();
        end
        wr_push = 1'b0;
        @(negedge clk);
        chk("t3_used_full", rd_used, 16);
        chk("t3_no_ovf_yet", overflow, 0);
        chk("t3_holding", out_valid, 1);
        tick();
        wr_push = 1'b1;
        wr_data = 64'h1FF;
        tick();
        wr_push = 1'b0;
        @(negedge clk);
        chk("t3_overflow", overflow, exp_ovf);
        chk("t3_overflow_set", overflow, 1);
        chk("t3_used_capped", rd_used, 16);
        tick();
        out_ready = 1'b1;
        repeat (45) tick();
        @(negedge clk);
        chk("t3_outputs", out_cnt - o0, 17);
        chk("t3_empty", rd_empty, 1);
        chk("t3_rd_ptr_wrap", rd_ptr, 1);
        chk("t3_overflow_sticky", overflow, 1);

        // 4. stall with valid output: data stable, no further fetch
        tick();
        out_ready = 1'b0;
        wr_push = 1'b1;
        wr_data = 64'hB1;
        tick();
        wr_data = 64'hB2;
        tick();
        wr_push = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_seen", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("t4_data_stable", out_data, 64'hB1);
            chk("t4_no_fetch", buf_rd_en, 0);
        end
        tick();
        out_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("t4_drained", rd_empty, 1);

        // 5. flush while in FETCH
        tick();
        p0 = pop_cnt;
        wr_push = 1'b1;
        wr_data = 64'hC1;
        tick();
        wr_push = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("t5_no_fetch_in_flush", buf_rd_en, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_rd_ptr", rd_ptr, 0);
        chk("t5_rd_used", rd_used, 0);
        chk("t5_overflow_kept", overflow, 1);
        chk("t5_pop_not_revoked", pop_cnt - p0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_stays_invalid", out_valid, 0);
        end

        // 6. fetch spacing (1G pacing when enabled, back-to-back otherwise)
        tick();
        mode_1g = 1'b1;
        out_ready = 1'b1;
        fetch_t.delete();
        for (int i = 0; i < 4; i++) begin
            wr_push = 1'b1;
            base_v = 64'hD0;
            wr_data = base_v + 64'(i);
            tick();
        end
        wr_push = 1'b0;
        repeat (60) tick();
        @(negedge clk);
        chk("t6_fetch_count", fetch_t.size(), 4);
        if (fetch_t.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("t6_fetch_gap", (fetch_t[i] - fetch_t[i-1]) / 10, GAP);
        end
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
